iter_log_mult_ctrl: RTL
=======================

Name: iter_log_mult_ctrl

Overview:
- Sequential controller for an iterative Mitchell-style logarithmic multiplier built around a leading-one detector and a 2^K generator.
- Accepts an unsigned operand pair, runs up to ITER refinement iterations (one per clock), accumulates partial products, and returns an approximate product.
- Sits in the approximate PE datapath between the operand feed and the MAC accumulator, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 8, operand width in bits.
- LOG2_WIDTH, 3, width of the leading-one index K; must equal ceil(log2(WIDTH)).
- ITER, 2, maximum refinement iterations per product (1..WIDTH). ITER=1 gives plain Mitchell.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  controller can accept an operand pair.
- A  input  WIDTH  unsigned multiplicand.
- B  input  WIDTH  unsigned multiplier.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts the product.
- P  output  2*WIDTH  approximate product.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Reset values: in_ready=0 while rst is high, then 1 from the first IDLE cycle. out_valid=0, P=0, busy=0. FSM=IDLE, iteration count=0, internal residues and accumulator=0.
- Reset mid-operation aborts the operation immediately, discards it, and returns the FSM to IDLE.
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1.
  - On in_valid&&in_ready: latch ra=A, rb=B; acc=0; cnt=0; go to CALC.
  - A is sampled only on this handshake.
- CALC: in_ready=0. One action per cycle, chosen in this order:
  - If ra==0 or rb==0: no accumulation; go to DONE.
  - Otherwise:
    - k1=index of the highest set bit of ra; k2=same for rb.
    - pp = (1<<(k1+k2)) + ((ra-(1<<k1))<<k2) + ((rb-(1<<k2))<<k1), computed at 2*WIDTH bits.
    - acc+=pp.
    - ra-=1<<k1; rb-=1<<k2.
    - cnt+=1.
    - If the new cnt==ITER, go to DONE; else stay in CALC.
- Accumulator arithmetic is modulo 2^(2*WIDTH). The approximation never exceeds the exact product, so no overflow occurs for legal operands.
- DONE: out_valid=1 and P=acc, both held stable until out_ready.
  - On out_valid&&out_ready: out_valid drops next cycle; go to IDLE.
  - P keeps its last value after the transfer.
- Latency: handshake accepted at edge T. out_valid is first seen after edge T+1+c, where c is the number of CALC cycles:
  - c = iterations performed, plus 1 if the run was terminated by a zero residual;
  - c is bounded by ITER+1 and is never more than ITER when no zero is hit.
- No back-to-back overlap: a new operand is accepted no earlier than the cycle after the output transfer.
- Backpressure: DONE holds indefinitely while out_ready=0.
- in_valid in CALC or DONE is ignored; the upstream source must hold it.
- Boundaries:
  - A=0 or B=0: c=1, P=0.
  - Exact powers of two: one iteration is exact, and the next CALC cycle terminates on the zero residual.
  - A=B=2^WIDTH-1 stays within 2*WIDTH bits.

Test Plan:
- Reset mid-CALC: assert rst during the first CALC cycle → out_valid=0, busy=0, P=0 asynchronously. After release, in_ready=1 and a new op (3*3) returns 9.
- ITER=2, A=3, B=3, out_ready=1: accept at T → iter1 acc=8, iter2 acc=9; out_valid after T+3, P=9. Repeat with ITER=1 → P=8 after T+2.
- ITER=2, A=7, B=5 → iter1 pp=32, iter2 pp=3; P=35 (exact).
- ITER=2, A=255, B=255 → pp1=48896, pp2=12160; P=61056. With ITER=1 → P=48896.
- Zero and early termination:
  - A=0, B=200 → P=0 after T+2.
  - A=4, B=16, ITER=2 → P=64 after T+3 (second CALC cycle detects the zero).
- Backpressure: hold out_ready=0 for 5 cycles in DONE (A=7, B=5) → P=35 and out_valid stay stable, in_ready=0, in_valid ignored. Raise out_ready → one transfer, then IDLE with in_ready=1 next cycle.

Source files
------------

// File: rtl/iter_log_mult_ctrl.sv
// rtl/iter_log_mult_ctrl.sv - iterative Mitchell-style logarithmic multiplier controller
// Each CALC cycle adds one Mitchell partial product and strips the leading ones from both residues.
module iter_log_mult_ctrl #(
  parameter int WIDTH      = 8,
  parameter int LOG2_WIDTH = 3,
  parameter int ITER       = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] P,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_next;
  logic [WIDTH-1:0] ra, rb, ra_next, rb_next;
  logic [PW-1:0]    acc, acc_next, p_reg, p_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [LOG2_WIDTH-1:0] k1, k2;
  logic [WIDTH-1:0] lead1, lead2;
  logic [PW-1:0]    pp;

  function automatic logic [LOG2_WIDTH-1:0] lod(input logic [WIDTH-1:0] v);
    lod = '0;
    for (int i = 0; i < WIDTH; i++)
      if (v[i]) lod = i[LOG2_WIDTH-1:0];
  endfunction

  assign k1    = lod(ra);
  assign k2    = lod(rb);
  assign lead1 = WIDTH'(1) << k1;
  assign lead2 = WIDTH'(1) << k2;
  // k1+k2 is widened so the sum cannot wrap in LOG2_WIDTH bits
  assign pp = (PW'(1) << (32'(k1) + 32'(k2)))
            + (PW'(ra - lead1) << k2)
            + (PW'(rb - lead2) << k1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      acc   <= '0;
      cnt   <= '0;
      p_reg <= '0;
    end else begin
      state <= state_next;
      ra    <= ra_next;
      rb    <= rb_next;
      acc   <= acc_next;
      cnt   <= cnt_next;
      p_reg <= p_next;
    end
  end

  always_comb begin
    state_next = state;
    ra_next    = ra;
    rb_next    = rb;
    acc_next   = acc;
    cnt_next   = cnt;
    p_next     = p_reg;
    case (state)
      IDLE: begin
        if (in_valid) begin
          ra_next    = A;
          rb_next    = B;
          acc_next   = '0;
          cnt_next   = '0;
          state_next = CALC;
        end
      end
      CALC: begin
        if (ra == '0 || rb == '0) begin
          p_next     = acc;
          state_next = DONE;
        end else begin
          acc_next = acc + pp;
          ra_next  = ra - lead1;
          rb_next  = rb - lead2;
          cnt_next = cnt + 1'b1;
          if (cnt_next == CW'(ITER)) begin
            p_next     = acc_next;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign P         = p_reg;

endmodule
